// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared field positions and FSM encoding for the fetch stage
package fetch_pkg;

   localparam int INSTR_WIDTH  = 32;

   localparam int ISBRANCH_BIT = 31;
   localparam int FORMAT_BIT   = 30;
   localparam int OPCODE_MSB   = 29;
   localparam int OPCODE_LSB   = 23;
   localparam int PRIM_MSB     = 22;
   localparam int PRIM_LSB     = 18;
   localparam int SEC_MSB      = 17;
   localparam int SEC_LSB      = 2;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FETCH    = 2'd1,
      S_REDIRECT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with clear; push and pop of different entries may share a cycle
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign head    = mem_q[rd_ptr_q];
   // An empty FIFO cannot pop the entry being pushed this cycle.
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && !clear && (!full || do_pop);

   always_ff @(posedge clock_i) begin
      if (!reset_ni || clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assert property (@(posedge clock_i) disable iff (!reset_ni)
                    !(push && !clear && full && !do_pop));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, credit-limited imem reads, buffering, redirect handling
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH   = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
   parameter int                  FIFO_DEPTH = 2
) (
   input  logic                   clock_i,
   input  logic                   reset_ni,
   input  logic                   enable_i,
   input  logic                   shouldStall_i,
   input  logic                   redirect_i,
   input  logic [PC_WIDTH-1:0]    redirectPc_i,
   output logic                   imemReq_o,
   output logic [PC_WIDTH-1:0]    imemAddr_o,
   input  logic                   imemReady_i,
   input  logic                   imemValid_i,
   input  logic [INSTR_WIDTH-1:0] imemData_i,
   output logic                   enable_o,
   output logic                   isBranch_o,
   output logic                   instructionFormat_o,
   output logic [6:0]             opcode_o,
   output logic [4:0]             primOperand_o,
   output logic [15:0]            secOperand_o,
   output logic                   flush_o,
   output logic [PC_WIDTH-1:0]    pc_o
);

   localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int              ENTRY_W = INSTR_WIDTH + PC_WIDTH;
   localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   fetch_state_t        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q;
   logic [CNT_W-1:0]    outstanding_q, outstanding_next, drop_count_q;
   logic                credit_ok, accept, resp_valid, resp_drop, resp_keep, out_load;
   logic                instr_pop, instr_full, instr_empty;
   logic [CNT_W-1:0]    instr_count;
   logic [ENTRY_W-1:0]  instr_head;
   logic [INSTR_WIDTH-1:0] head_word;
   logic                tag_full, tag_empty;
   logic [CNT_W-1:0]    tag_count;
   logic [PC_WIDTH-1:0] tag_head;
   logic                unused_status;

   assign imemAddr_o = pc_q;
   assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, instr_count}) < DEPTH_C;
   assign accept     = imemReq_o && imemReady_i;
   // A response with nothing outstanding is a stray (e.g. from before reset) and is ignored.
   assign resp_valid = imemValid_i && (outstanding_q != '0);
   assign resp_drop  = resp_valid && (redirect_i || (drop_count_q != '0));
   assign resp_keep  = resp_valid && !resp_drop;
   assign out_load   = !enable_o || !shouldStall_i;
   assign instr_pop  = !redirect_i && out_load && !instr_empty;
   assign head_word  = instr_head[ENTRY_W-1:PC_WIDTH];
   assign unused_status = ^{head_word[SEC_LSB-1:0], instr_full, tag_full, tag_empty, tag_count};

   always_comb begin
      outstanding_next = outstanding_q;
      if (accept && !resp_valid)      outstanding_next = outstanding_q + 1'b1;
      else if (!accept && resp_valid) outstanding_next = outstanding_q - 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      imemReq_o = 1'b0;
      unique case (state_q)
         S_IDLE:     if (enable_i) state_d = S_FETCH;
         S_FETCH:    imemReq_o = enable_i && !redirect_i && credit_ok;
         S_REDIRECT: state_d = S_FETCH;
         default:    state_d = S_IDLE;
      endcase
      if (redirect_i) state_d = S_REDIRECT;
   end

   // Redirect snapshots the post-accounting outstanding count as the number of stale words to drop.
   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_count_q  <= '0;
         flush_o       <= 1'b0;
      end else begin
         outstanding_q <= outstanding_next;
         flush_o       <= redirect_i;
         if (redirect_i) begin
            pc_q         <= redirectPc_i;
            drop_count_q <= outstanding_next;
         end else begin
            if (accept)    pc_q         <= pc_q + 1'b1;
            if (resp_drop) drop_count_q <= drop_count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         enable_o            <= 1'b0;
         isBranch_o          <= 1'b0;
         instructionFormat_o <= 1'b0;
         opcode_o            <= '0;
         primOperand_o       <= '0;
         secOperand_o        <= '0;
         pc_o                <= RESET_PC;
      end else if (redirect_i) begin
         enable_o <= 1'b0;
      end else if (out_load) begin
         enable_o <= !instr_empty;
         if (!instr_empty) begin
            isBranch_o          <= head_word[ISBRANCH_BIT];
            instructionFormat_o <= head_word[FORMAT_BIT];
            opcode_o            <= head_word[OPCODE_MSB:OPCODE_LSB];
            primOperand_o       <= head_word[PRIM_MSB:PRIM_LSB];
            secOperand_o        <= head_word[SEC_MSB:SEC_LSB];
            pc_o                <= instr_head[PC_WIDTH-1:0];
         end
      end
   end

   fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
      .clock_i   (clock_i),
      .reset_ni  (reset_ni),
      .clear     (redirect_i),
      .push      (resp_keep),
      .push_data ({imemData_i, tag_head}),
      .pop       (instr_pop),
      .head      (instr_head),
      .full      (instr_full),
      .empty     (instr_empty),
      .count     (instr_count)
   );

   fetch_fifo #(.WIDTH(PC_WIDTH), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
      .clock_i   (clock_i),
      .reset_ni  (reset_ni),
      .clear     (redirect_i),
      .push      (accept),
      .push_data (pc_q),
      .pop       (resp_keep),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (tag_count)
   );

   assert property (@(posedge clock_i) disable iff (!reset_ni)
                    imemValid_i |-> (outstanding_q != '0));

endmodule
